// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed byte stream,
// packs payload bytes into little-endian 32-bit words, writes them from word 0
// upward, and raises cpu_start_o only after the XOR checksum byte matches.
module imem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_req_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   output logic                  byte_ready_o,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic                  cpu_start_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t                state, state_next;
   logic [7:0]            len_lo;
   logic [15:0]           len;
   logic [1:0]            byte_idx;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [23:0]           word_buf;
   logic [7:0]            csum;

   logic        take;
   logic        start_load;
   logic [15:0] len_full;
   logic        last_word;

   assign take       = byte_valid_i & byte_ready_o;
   assign start_load = load_req_i &
                       ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
   assign len_full   = {byte_data_i, len_lo};
   assign last_word  = (16'(word_idx) == (len - 16'd1));

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state decode; a word boundary and the last word together end the payload
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (load_req_i) state_next = S_LEN_LO;
         S_LEN_LO: if (take) state_next = S_LEN_HI;
         S_LEN_HI: begin
            if (take) begin
               if (len_full > 16'(DEPTH))   state_next = S_ERROR;
               else if (len_full == 16'd0)  state_next = S_CHECK;
               else                         state_next = S_DATA;
            end
         end
         S_DATA: if (take && (byte_idx == 2'd3) && last_word) state_next = S_CHECK;
         S_CHECK: if (take) state_next = (byte_data_i == csum) ? S_DONE : S_ERROR;
         default: state_next = S_IDLE;
      endcase
   end

   // Registered status and handshake outputs, decoded from the upcoming state
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         byte_ready_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         cpu_start_o  <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         byte_ready_o <= (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                         (state_next == S_DATA)   || (state_next == S_CHECK);
         busy_o       <= (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                         (state_next == S_DATA)   || (state_next == S_CHECK);
         done_o       <= (state_next == S_DONE);
         cpu_start_o  <= (state_next == S_DONE);
         error_o      <= (state_next == S_ERROR);
      end
   end

   // Length capture, byte packing, checksum and the one-cycle write strobe
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         len_lo      <= 8'd0;
         len         <= 16'd0;
         byte_idx    <= 2'd0;
         word_idx    <= '0;
         word_buf    <= 24'd0;
         csum        <= 8'd0;
         imem_we_o   <= 1'b0;
         imem_addr_o <= '0;
         imem_data_o <= 32'd0;
      end else begin
         imem_we_o <= 1'b0;
         if (start_load) begin
            byte_idx <= 2'd0;
            word_idx <= '0;
            csum     <= 8'd0;
         end
         if (take) begin
            case (state)
               S_LEN_LO: len_lo <= byte_data_i;
               S_LEN_HI: len    <= len_full;
               S_DATA: begin
                  csum     <= csum ^ byte_data_i;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= byte_data_i;
                     2'd1: word_buf[15:8]  <= byte_data_i;
                     2'd2: word_buf[23:16] <= byte_data_i;
                     default: begin
                        // 4th byte completes the word; write goes out next cycle
                        imem_we_o   <= 1'b1;
                        imem_addr_o <= word_idx;
                        imem_data_o <= {byte_data_i, word_buf};
                        word_idx    <= word_idx + 1'b1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the short
// scenarios plus streaming sequences for multi-word, boundary and reset cases.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        busy, done, error, cpu_start;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
      .clk_i(clk), .rst_i(rst), .load_req_i(load_req),
      .byte_valid_i(byte_valid), .byte_data_i(byte_data),
      .byte_ready_o(byte_ready), .imem_we_o(imem_we),
      .imem_addr_o(imem_addr), .imem_data_o(imem_data),
      .busy_o(busy), .done_o(done), .error_o(error), .cpu_start_o(cpu_start)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        lr;
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        bsy;
      logic        dn;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic lr, input logic v, input logic [7:0] d,
                      input logic rdy, input logic we, input logic [7:0] addr,
                      input logic [31:0] data, input logic bsy, input logic dn,
                      input logic err);
      vec_t r;
      r.lr = lr; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
      r.data = data; r.bsy = bsy; r.dn = dn; r.err = err;
      vecs.push_back(r);
   endtask

   function automatic logic [63:0] outs();
      return 64'({byte_ready, imem_we, imem_addr, imem_data, busy, done, error, cpu_start});
   endfunction

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps) begin
         int g;
         g = $urandom_range(0, 2);
         repeat (g) @(negedge clk);
      end
      @(negedge clk);
      chk("ready_before_byte", 64'(byte_ready), 64'd1);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input int n, input bit gaps, input logic [7:0] seed);
      logic [7:0]  cs;
      logic [31:0] w;
      logic [7:0]  b;
      cs = 8'd0;
      w  = 32'd0;
      pulse_load();
      send_byte(n[7:0], gaps);
      send_byte(n[15:8], gaps);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            b = seed ^ 8'(i * 13 + j * 5 + 1);
            cs = cs ^ b;
            w[8*j +: 8] = b;
            send_byte(b, gaps);
            if (j == 3)
               chk("word_write", 64'({imem_we, imem_addr, imem_data}), 64'({1'b1, i[7:0], w}));
            else
               chk("no_write_midword", 64'(imem_we), 64'd0);
         end
      end
      send_byte(cs, gaps);
      chk("load_done", 64'({byte_ready, busy, done, error, cpu_start}), 64'b00101);
   endtask

   initial begin
      rst = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
      #1 rst = 1'b0;
      #2 chk("reset_async", outs(), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset_idle", outs(), 64'd0);

      // Single word 0x00000013, correct checksum, then ignored bytes in DONE
      add(1,0,8'h00, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h01, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h13, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h0, 1,0,0);
      add(0,1,8'h00, 1,1,8'd0,32'h13, 1,0,0);
      add(0,1,8'h13, 0,0,8'd0,32'h13, 0,1,0);
      add(0,0,8'h00, 0,0,8'd0,32'h13, 0,1,0);
      add(0,1,8'h55, 0,0,8'd0,32'h13, 0,1,0);
      // Two words, wrong checksum (correct is 0x88); load_req mid-payload ignored
      add(1,0,8'h00, 1,0,8'd0,32'h13, 1,0,0);
      add(0,1,8'h02, 1,0,8'd0,32'h13, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h13, 1,0,0);
      add(0,1,8'h11, 1,0,8'd0,32'h13, 1,0,0);
      add(1,1,8'h22, 1,0,8'd0,32'h13, 1,0,0);
      add(0,1,8'h33, 1,0,8'd0,32'h13, 1,0,0);
      add(0,1,8'h44, 1,1,8'd0,32'h44332211, 1,0,0);
      add(0,1,8'h55, 1,0,8'd0,32'h44332211, 1,0,0);
      add(0,1,8'h66, 1,0,8'd0,32'h44332211, 1,0,0);
      add(0,1,8'h77, 1,0,8'd0,32'h44332211, 1,0,0);
      add(0,1,8'h88, 1,1,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h00, 0,0,8'd1,32'h88776655, 0,0,1);
      add(0,0,8'h00, 0,0,8'd1,32'h88776655, 0,0,1);
      // Reload from ERROR: one word 0x12345678, checksum 0x08
      add(1,0,8'h00, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h01, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h00, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h78, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h56, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h34, 1,0,8'd1,32'h88776655, 1,0,0);
      add(0,1,8'h12, 1,1,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h08, 0,0,8'd0,32'h12345678, 0,1,0);
      // N=257 exceeds DEPTH: ERROR straight after LEN_HI, bytes ignored
      add(1,0,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h01, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h01, 0,0,8'd0,32'h12345678, 0,0,1);
      add(0,1,8'hAA, 0,0,8'd0,32'h12345678, 0,0,1);
      // N=0: checksum 00 -> DONE, checksum 01 -> ERROR
      add(1,0,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h00, 0,0,8'd0,32'h12345678, 0,1,0);
      add(1,0,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h00, 1,0,8'd0,32'h12345678, 1,0,0);
      add(0,1,8'h01, 0,0,8'd0,32'h12345678, 0,0,1);

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         load_req   = vecs[k].lr;
         byte_valid = vecs[k].v;
         byte_data  = vecs[k].d;
         @(posedge clk); #1;
         chk($sformatf("vec%0d", k), outs(),
             64'({vecs[k].rdy, vecs[k].we, vecs[k].addr, vecs[k].data,
                  vecs[k].bsy, vecs[k].dn, vecs[k].err, vecs[k].dn}));
         load_req   = 1'b0;
         byte_valid = 1'b0;
      end

      // Three words back-to-back, then the N==DEPTH boundary
      run_load(3, 1'b0, 8'h5A);
      run_load(256, 1'b0, 8'hC3);

      // Reset in the middle of the payload, then reload with valid gaps
      pulse_load();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int j = 0; j < 5; j++) send_byte(8'(j + 8'h40), 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("reset_mid_data", outs(), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("after_reset_idle", outs(), 64'd0);
      run_load(4, 1'b1, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
